axi_lite_mem_master: RTL and testbench
======================================

# axi_lite_mem_master

Initiator-side bridge that turns a simple single-outstanding memory request port (ren/wen, addr, wdata, wmask) into AXI4-Lite master transactions. It is the counterpart of the slave-side mem-to-AXI-lite adapter used by the MMIO peripherals such as the displayer. It sits between a core or DMA-style requester and the AXI-lite interconnect. It keeps one transaction in flight and reports completion, read data and bus errors back to the requester.

## Interface
- C_M_AXI_DATA_WIDTH, 64, data width of the AXI and mem ports; a multiple of 8.
- C_M_AXI_ADDR_WIDTH, 64, address width of the AXI and mem ports.
- clk  in  1  single clock for all logic.
- rstn  in  1  reset; asynchronous assertion, active-low.
- mem_ren / mem_wen  in  1  read / write request level, held until the completion pulse.
- mem_addr  in  ADDR_WIDTH  byte address.
- mem_wdata  in  DATA_WIDTH  write data.
- mem_wmask  in  DATA_WIDTH/8  byte enables, driven to wstrb.
- mem_rdata  out  DATA_WIDTH  read data, valid while mem_rvalid=1.
- mem_rvalid / mem_wvalid  out  1  one-cycle read / write completion pulse.
- mem_err  out  1  pulses with a completion whose response was not OKAY.
- m_awaddr, m_awvalid, m_awready, m_wdata, m_wstrb, m_wvalid, m_wready, m_bresp[1:0], m_bvalid, m_bready, m_araddr, m_arvalid, m_arready, m_rdata, m_rresp[1:0], m_rvalid, m_rready  AXI4-Lite master channels with the standard directions and widths. awprot and arprot are tied to 3'b000.

## Operation
- FSM states: IDLE, WADDR (AW and W phase), WRESP, RADDR, RDATA, DONE.
- IDLE: if mem_wen=1, register addr, wdata and wmask, then go to WADDR. Else if mem_ren=1, register addr, then go to RADDR. When both are asserted, the write wins and the read is not lost: it stays asserted and is served after DONE.
- WADDR: m_awvalid and m_wvalid are asserted together. aw_done and w_done flags track each handshake independently and may complete in either order or in the same cycle. Each valid drops in the cycle after its own handshake. Exit to WRESP once both flags are set, including the case where both set in the same cycle.
- WRESP: m_bready=1. On m_bvalid, latch err = (bresp != 2'b00) and go to DONE.
- RADDR: m_arvalid=1 until m_arready, then go to RDATA.
- RDATA: m_rready=1. On m_rvalid, latch rdata and err = (rresp != 2'b00), then go to DONE.
- DONE lasts one cycle. It pulses mem_wvalid or mem_rvalid according to the finished operation, pulses mem_err if err is set, and then returns to IDLE. The requester deasserts its request in the cycle after the pulse; IDLE does not sample the request in the DONE cycle.
- AXI rules: a valid, once asserted, holds until ready, with address, data and strobe stable. No valid depends combinationally on a ready. bready and rready are asserted only in their own states.
- Request inputs are ignored outside IDLE. A change of mem_addr mid-transaction has no effect.
- Reset (asynchronous, any state): go to IDLE, and all outputs go to 0, including every valid, ready, pulse, mem_rdata and the registered address and data. Reset in the middle of a handshake abandons the transaction with no completion pulse.

## Timing
- All outputs are registered or decoded from state only, with no input-to-output combinational path.
- Request seen in IDLE at cycle t: the valids assert at t+1.
- Minimum write latency is 3 cycles (zero-wait slave: AW and W accepted at t+1, B at t+2, mem_wvalid at t+3).
- Minimum read latency is 3 cycles (AR accepted at t+1, R at t+2, mem_rvalid at t+3).
- Each ready or response wait cycle adds exactly one cycle. There is no timeout.
- The next request is accepted at t+4 at the earliest.
- mem_rdata holds its value from DONE until the next read completes.

## Test plan
- Zero-wait write of addr 0x1000_0000, wdata 0x1122334455667788, wmask 0xFF. Required: awaddr, wdata and wstrb=0xFF appear at t+1, and mem_wvalid pulses at t+3 with mem_err=0.
- Write with skewed readies: awready at t+1, wready at t+4, bvalid 2 cycles later. Required: awvalid drops at t+2 while wvalid holds with stable data until t+4, and mem_wvalid comes exactly one cycle after the B handshake.
- Read with arready delayed 3 cycles and rdata 0xDEADBEEF_CAFEBABE. Required: mem_rvalid pulses once with that value, and mem_rdata still holds it 5 cycles later.
- Read returning rresp=2'b10. Required: mem_rvalid and mem_err pulse in the same cycle.
- mem_ren and mem_wen asserted together at addr 0x40. Required: the full write transaction completes first, then the read issues (arvalid at DONE+2), and each completion pulses exactly once.
- rstn pulsed low while awvalid=1 and awready=0. Required: all outputs are 0 immediately, the FSM is in IDLE, no completion pulse occurs, and a fresh write afterwards completes normally.

Source files
------------

// File: rtl/axi_lite_mem_master.sv
// axi_lite_mem_master: single-outstanding mem request port to AXI4-Lite master.
// One transaction in flight; completion, read data and error reported back.
module axi_lite_mem_master #(
    parameter int C_M_AXI_DATA_WIDTH = 64,
    parameter int C_M_AXI_ADDR_WIDTH = 64
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            mem_ren,
    input  logic                            mem_wen,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   mem_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   mem_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] mem_wmask,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   mem_rdata,
    output logic                            mem_rvalid,
    output logic                            mem_wvalid,
    output logic                            mem_err,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]                      m_awprot,
    output logic                            m_awvalid,
    input  logic                            m_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_wstrb,
    output logic                            m_wvalid,
    input  logic                            m_wready,
    input  logic [1:0]                      m_bresp,
    input  logic                            m_bvalid,
    output logic                            m_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]                      m_arprot,
    output logic                            m_arvalid,
    input  logic                            m_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]                      m_rresp,
    input  logic                            m_rvalid,
    output logic                            m_rready
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WADDR = 3'd1;
    localparam logic [2:0] WRESP = 3'd2;
    localparam logic [2:0] RADDR = 3'd3;
    localparam logic [2:0] RDATA = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]                    r_state;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]             r_wmask;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_rdata;
    logic                          r_awvalid;
    logic                          r_wvalid;
    logic                          r_arvalid;
    logic                          r_err;
    logic                          r_is_read;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_done;
    logic w_w_done;

    // A channel counts as done once its valid has dropped or it handshakes now.
    always_comb begin
        w_aw_hs   = r_awvalid & m_awready;
        w_w_hs    = r_wvalid & m_wready;
        w_aw_done = ~r_awvalid | w_aw_hs;
        w_w_done  = ~r_wvalid | w_w_hs;
    end

    // Transaction FSM with registered valids, address, data and response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wmask   <= '0;
            r_rdata   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_err     <= 1'b0;
            r_is_read <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mem_wen) begin
                        r_addr    <= mem_addr;
                        r_wdata   <= mem_wdata;
                        r_wmask   <= mem_wmask;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_is_read <= 1'b0;
                        r_state   <= WADDR;
                    end else if (mem_ren) begin
                        r_addr    <= mem_addr;
                        r_arvalid <= 1'b1;
                        r_is_read <= 1'b1;
                        r_state   <= RADDR;
                    end
                end
                WADDR: begin
                    if (w_aw_hs) r_awvalid <= 1'b0;
                    if (w_w_hs) r_wvalid <= 1'b0;
                    if (w_aw_done && w_w_done) r_state <= WRESP;
                end
                WRESP: begin
                    if (m_bvalid) begin
                        r_err   <= |m_bresp;
                        r_state <= DONE;
                    end
                end
                RADDR: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (m_rvalid) begin
                        r_rdata <= m_rdata;
                        r_err   <= |m_rresp;
                        r_state <= DONE;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs come straight from registers or from the state decode.
    always_comb begin
        m_awaddr   = r_addr;
        m_araddr   = r_addr;
        m_wdata    = r_wdata;
        m_wstrb    = r_wmask;
        m_awvalid  = r_awvalid;
        m_wvalid   = r_wvalid;
        m_arvalid  = r_arvalid;
        m_awprot   = 3'b000;
        m_arprot   = 3'b000;
        m_bready   = (r_state == WRESP);
        m_rready   = (r_state == RDATA);
        mem_rdata  = r_rdata;
        mem_wvalid = (r_state == DONE) & ~r_is_read;
        mem_rvalid = (r_state == DONE) & r_is_read;
        mem_err    = (r_state == DONE) & r_err;
    end

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// tb_axi_lite_mem_master: directed cycle-by-cycle stimulus for the
// mem-to-AXI4-Lite master bridge with hand-computed expectations.
module tb_axi_lite_mem_master;

    logic        clk;
    logic        rstn;
    logic        mem_ren;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_wvalid;
    logic        mem_err;
    logic [63:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [63:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [63:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    int n_chk  = 0;
    int n_fail = 0;

    axi_lite_mem_master #(
        .C_M_AXI_DATA_WIDTH(64),
        .C_M_AXI_ADDR_WIDTH(64)
    ) dut (
        .clk(clk), .rstn(rstn),
        .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .mem_wvalid(mem_wvalid),
        .mem_err(mem_err),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid),
        .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot),
        .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        mem_ren = 0; mem_wen = 0;
        mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
        m_awready = 0; m_wready = 0;
        m_bresp = 0; m_bvalid = 0;
        m_arready = 0; m_rdata = '0;
        m_rresp = 0; m_rvalid = 0;
        step(); step();
        check("rst_awvalid", m_awvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_arvalid", m_arvalid, 0);
        check("rst_bready", m_bready, 0);
        check("rst_rready", m_rready, 0);
        check("rst_pulses", {mem_wvalid, mem_rvalid, mem_err}, 0);
        check("rst_rdata", mem_rdata, 0);
        check("rst_prot", {m_awprot, m_arprot}, 0);
        #2 rstn = 1'b1;
        step();

        // 1: zero-wait write
        mem_wen = 1; mem_addr = 64'h1000_0000;
        mem_wdata = 64'h1122334455667788; mem_wmask = 8'hFF;
        step();
        check("w1_awvalid", m_awvalid, 1);
        check("w1_wvalid", m_wvalid, 1);
        check("w1_awaddr", m_awaddr, 64'h1000_0000);
        check("w1_wdata", m_wdata, 64'h1122334455667788);
        check("w1_wstrb", m_wstrb, 8'hFF);
        check("w1_noready", {m_bready, m_rready}, 0);
        m_awready = 1; m_wready = 1;
        step();
        check("w1_valids_drop", {m_awvalid, m_wvalid}, 0);
        check("w1_bready", m_bready, 1);
        check("w1_no_early", mem_wvalid, 0);
        m_awready = 0; m_wready = 0; m_bvalid = 1; m_bresp = 0;
        step();
        check("w1_wpulse", mem_wvalid, 1);
        check("w1_err", mem_err, 0);
        check("w1_rpulse", mem_rvalid, 0);
        check("w1_bready_off", m_bready, 0);
        m_bvalid = 0; mem_wen = 0;
        step();
        check("w1_one_pulse", mem_wvalid, 0);

        // 2: skewed readies
        mem_wen = 1; mem_addr = 64'h2000;
        mem_wdata = 64'hA5A5_0000_5A5A_FFFF; mem_wmask = 8'h0F;
        step();
        check("w2_both_valid", {m_awvalid, m_wvalid}, 2'b11);
        m_awready = 1;
        mem_addr = 64'hBAD0; mem_wdata = 64'h0;
        step();
        check("w2_aw_drop", {m_awvalid, m_wvalid}, 2'b01);
        m_awready = 0;
        step();
        check("w2_w_hold", m_wvalid, 1);
        check("w2_wdata_stable", m_wdata, 64'hA5A5_0000_5A5A_FFFF);
        check("w2_wstrb_stable", m_wstrb, 8'h0F);
        check("w2_addr_stable", m_awaddr, 64'h2000);
        step();
        check("w2_w_hold4", m_wvalid, 1);
        check("w2_no_bready", m_bready, 0);
        m_wready = 1;
        step();
        check("w2_w_drop", m_wvalid, 0);
        check("w2_bready", m_bready, 1);
        m_wready = 0;
        step();
        check("w2_wait_b", {m_bready, mem_wvalid}, 2'b10);
        m_bvalid = 1; m_bresp = 2'b00;
        step();
        check("w2_wpulse", mem_wvalid, 1);
        check("w2_err", mem_err, 0);
        m_bvalid = 0; mem_wen = 0;
        step();
        check("w2_one_pulse", mem_wvalid, 0);

        // 3: read with arready delayed 3 cycles
        mem_ren = 1; mem_addr = 64'h3000;
        step();
        check("r3_arvalid", m_arvalid, 1);
        check("r3_araddr", m_araddr, 64'h3000);
        step();
        step();
        check("r3_ar_hold", m_arvalid, 1);
        check("r3_no_rready", m_rready, 0);
        step();
        m_arready = 1;
        step();
        check("r3_ar_drop", m_arvalid, 0);
        check("r3_rready", m_rready, 1);
        m_arready = 0; m_rvalid = 1;
        m_rdata = 64'hDEADBEEF_CAFEBABE; m_rresp = 0;
        step();
        check("r3_rpulse", mem_rvalid, 1);
        check("r3_rdata", mem_rdata, 64'hDEADBEEF_CAFEBABE);
        check("r3_err", mem_err, 0);
        check("r3_wpulse", mem_wvalid, 0);
        m_rvalid = 0; m_rdata = '0; mem_ren = 0;
        begin
            int pulses = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                if (mem_rvalid) pulses++;
            end
            check("r3_one_pulse", pulses, 0);
        end
        check("r3_rdata_hold", mem_rdata, 64'hDEADBEEF_CAFEBABE);

        // 4: read with SLVERR
        mem_ren = 1; mem_addr = 64'h50;
        step();
        m_arready = 1;
        step();
        m_arready = 0; m_rvalid = 1;
        m_rdata = 64'h0123_4567_89AB_CDEF; m_rresp = 2'b10;
        step();
        check("r4_rpulse_err", {mem_rvalid, mem_err}, 2'b11);
        check("r4_rdata", mem_rdata, 64'h0123_4567_89AB_CDEF);
        m_rvalid = 0; m_rresp = 0; mem_ren = 0;
        step();
        check("r4_err_clear", {mem_rvalid, mem_err}, 0);

        // 5: read and write together; write first
        mem_ren = 1; mem_wen = 1; mem_addr = 64'h40;
        mem_wdata = 64'h77; mem_wmask = 8'h01;
        step();
        check("b5_write_first", {m_awvalid, m_wvalid, m_arvalid}, 3'b110);
        m_awready = 1; m_wready = 1;
        step();
        m_awready = 0; m_wready = 0; m_bvalid = 1;
        step();
        check("b5_wpulse", {mem_wvalid, mem_rvalid}, 2'b10);
        m_bvalid = 0; mem_wen = 0;
        step();
        check("b5_idle_gap", {m_arvalid, mem_wvalid}, 0);
        step();
        check("b5_arvalid", m_arvalid, 1);
        check("b5_araddr", m_araddr, 64'h40);
        m_arready = 1;
        step();
        m_arready = 0; m_rvalid = 1; m_rdata = 64'h1234;
        step();
        check("b5_rpulse", {mem_wvalid, mem_rvalid}, 2'b01);
        check("b5_rdata", mem_rdata, 64'h1234);
        m_rvalid = 0; mem_ren = 0;
        step();
        check("b5_no_more", {mem_wvalid, mem_rvalid}, 0);

        // 6: reset during AW wait
        mem_wen = 1; mem_addr = 64'h60;
        mem_wdata = 64'h99; mem_wmask = 8'hF0;
        step();
        check("x6_awvalid", m_awvalid, 1);
        #2 rstn = 1'b0;
        #1;
        check("x6_valids", {m_awvalid, m_wvalid, m_arvalid}, 0);
        check("x6_readies", {m_bready, m_rready}, 0);
        check("x6_pulses", {mem_wvalid, mem_rvalid, mem_err}, 0);
        check("x6_rdata", mem_rdata, 0);
        check("x6_addr", m_awaddr, 0);
        check("x6_wdata", {m_wdata, m_wstrb}, 0);
        check("x6_state", dut.r_state, 0);
        mem_wen = 0;
        step();
        #2 rstn = 1'b1;
        begin
            int pulses = 0;
            for (int i = 0; i < 3; i++) begin
                step();
                if (mem_wvalid | mem_rvalid | m_awvalid) pulses++;
            end
            check("x6_quiet", pulses, 0);
        end
        mem_wen = 1; mem_addr = 64'h80;
        mem_wdata = 64'hFEED; mem_wmask = 8'h03;
        step();
        check("x6_new_aw", {m_awvalid, m_wvalid}, 2'b11);
        check("x6_new_addr", m_awaddr, 64'h80);
        m_awready = 1; m_wready = 1;
        step();
        m_awready = 0; m_wready = 0; m_bvalid = 1; m_bresp = 2'b11;
        step();
        check("x6_new_pulse", {mem_wvalid, mem_err}, 2'b11);
        m_bvalid = 0; m_bresp = 0; mem_wen = 0;
        step();
        check("x6_new_done", {mem_wvalid, mem_err}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
